irq_ctrl: RTL and testbench

- Interrupt controller directly upstream of the 4-bit CPU core.
- Synchronises four external interrupt sources and detects edges or levels per source.
- Latches pending requests, masks them with the CPU's `ie` output, and drives the CPU `irq` input.
- On the CPU's `ack` pulse it retires the winning source and holds a cause nibble, which the board muxes onto the CPU `in` port while the handler runs.

---
 rtl/irq_ctrl_if.sv | 13 +
 rtl/irq_ctrl.sv | 84 ++++++++
 tb/tb_irq_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/irq_ctrl_if.sv
// Signal bundle between the interrupt controller and the CPU/board side.
// The master drives sources, enables and ack; the slave returns irq, cause and pending.
interface irq_ctrl_if;
  logic [3:0] src;
  logic [3:0] ie;
  logic       ack;
  logic       irq;
  logic [3:0] cause;
  logic [3:0] pending_o;

  modport master (output src, ie, ack, input irq, cause, pending_o);
  modport slave  (input src, ie, ack, output irq, cause, pending_o);
endinterface

// File: rtl/irq_ctrl.sv
// Four-source interrupt controller: synchronise, edge/level detect, latch pending,
// mask with ie, and on ack retire the lowest-index winner into a held cause nibble.
module irq_ctrl #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [3:0] EDGE_MASK   = 4'b1111
) (
  input  logic      clock,
  input  logic      reset,
  irq_ctrl_if.slave bus
);

  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] hist_q;
  logic [3:0] pending_q, pending_d;
  logic [3:0] lost_q,    lost_d;
  logic [3:0] cause_q,   cause_d;

  logic [3:0] sync_s;
  logic [3:0] rise;
  logic [3:0] req;
  logic       win_vld;
  logic [1:0] win_id;

  assign sync_s = sync_q[SYNC_STAGES-1];
  assign rise   = sync_s & ~hist_q & EDGE_MASK;
  assign req    = pending_q & bus.ie;

  // Scan from the top so the lowest requesting index is the last one written.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    win_vld = 1'b0;
    win_id  = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) begin
        win_vld = 1'b1;
        win_id  = 2'(i);
      end
    end
  end

  always_comb begin
    // Edge bits accumulate; level bits simply follow the synchronised input.
    pending_d = ((pending_q | rise) & EDGE_MASK) | (sync_s & ~EDGE_MASK);
    lost_d    = lost_q | (rise & pending_q);
    cause_d   = cause_q;
    if (bus.ack) begin
      if (win_vld) begin
        cause_d = {1'b1, lost_q[win_id], win_id};
        // A fresh edge in the ack cycle keeps the source pending but starts lost afresh.
        if (EDGE_MASK[win_id]) begin
          pending_d[win_id] = rise[win_id];
          lost_d[win_id]    = 1'b0;
        end
      end else begin
        cause_d = 4'b0000;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      // NOTE: the synchroniser array is reset too, so a source held high through reset
      // shows up as exactly one clean rising edge after release.
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      hist_q    <= '0;
      pending_q <= '0;
      lost_q    <= '0;
      cause_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      sync_q[0] <= bus.src;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      hist_q    <= sync_s;
      pending_q <= pending_d;
      lost_q    <= lost_d;
      cause_q   <= cause_d;
    end
  end

  assign bus.irq       = |req;
  assign bus.cause     = cause_q;
  assign bus.pending_o = pending_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: a per-cycle vector table on the default (all-edge)
// instance, plus hand sequences for masking and a level-triggered instance.
module tb_irq_ctrl;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  irq_ctrl_if bus ();
  irq_ctrl_if lbus ();

  irq_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  irq_ctrl #(.SYNC_STAGES(2), .EDGE_MASK(4'b1110)) dut_lvl (
    .clock (clock),
    .reset (reset),
    .bus   (lbus)
  );

  typedef struct {
    logic       rst_n;
    logic [3:0] src;
    logic [3:0] ie;
    logic       ack;
    logic       irq;
    logic [3:0] cause;
    logic [3:0] pend;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic add(input logic r, input logic [3:0] s, input logic [3:0] e,
                     input logic a, input logic i, input logic [3:0] c,
                     input logic [3:0] p);
    vec_t v;
    v.rst_n = r; v.src = s; v.ie = e; v.ack = a;
    v.irq = i; v.cause = c; v.pend = p;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    bus.src = '0;  bus.ie = '0;  bus.ack = 1'b0;
    lbus.src = '0; lbus.ie = '0; lbus.ack = 1'b0;

    //    rst  src      ie       ack  irq   cause    pend
    // Reset dominates src and ack; a source held high presents one edge after release.
    add(0, 4'hF,    4'hF,    1, 0, 4'b0000, 4'b0000);
    add(0, 4'hF,    4'hF,    1, 0, 4'b0000, 4'b0000);
    add(1, 4'hF,    4'h0,    0, 0, 4'b0000, 4'b0000);
    add(1, 4'hF,    4'h0,    0, 0, 4'b0000, 4'b0000);
    add(1, 4'hF,    4'h0,    0, 0, 4'b0000, 4'b1111);
    // Drain in priority order.
    add(1, 4'hF,    4'hF,    1, 1, 4'b1000, 4'b1110);
    add(1, 4'hF,    4'hF,    1, 1, 4'b1001, 4'b1100);
    add(1, 4'hF,    4'hF,    1, 1, 4'b1010, 4'b1000);
    add(1, 4'hF,    4'hF,    1, 0, 4'b1011, 4'b0000);
    add(1, 4'h0,    4'h0,    0, 0, 4'b1011, 4'b0000);
    add(1, 4'h0,    4'h0,    0, 0, 4'b1011, 4'b0000);
    add(1, 4'h0,    4'h0,    0, 0, 4'b1011, 4'b0000);
    // Latency: src[0] pulse sampled at edge N -> irq after edge N+2; then ack.
    add(1, 4'b0001, 4'b0001, 0, 0, 4'b1011, 4'b0000);
    add(1, 4'b0000, 4'b0001, 0, 0, 4'b1011, 4'b0000);
    add(1, 4'b0000, 4'b0001, 0, 1, 4'b1011, 4'b0001);
    add(1, 4'b0000, 4'b0001, 1, 0, 4'b1000, 4'b0000);
    // Priority: simultaneous edges on 1 and 2.
    add(1, 4'b0110, 4'hF,    0, 0, 4'b1000, 4'b0000);
    add(1, 4'b0110, 4'hF,    0, 0, 4'b1000, 4'b0000);
    add(1, 4'b0110, 4'hF,    0, 1, 4'b1000, 4'b0110);
    add(1, 4'b0110, 4'hF,    1, 1, 4'b1001, 4'b0100);
    add(1, 4'b0110, 4'hF,    1, 0, 4'b1010, 4'b0000);
    add(1, 4'b0000, 4'h0,    0, 0, 4'b1010, 4'b0000);
    add(1, 4'b0000, 4'h0,    0, 0, 4'b1010, 4'b0000);
    // Lost: two edges on src[3] while disabled, then enable and ack.
    add(1, 4'b1000, 4'h0,    0, 0, 4'b1010, 4'b0000);
    add(1, 4'b0000, 4'h0,    0, 0, 4'b1010, 4'b0000);
    add(1, 4'b1000, 4'h0,    0, 0, 4'b1010, 4'b1000);
    add(1, 4'b0000, 4'h0,    0, 0, 4'b1010, 4'b1000);
    add(1, 4'b0000, 4'h0,    0, 0, 4'b1010, 4'b1000);
    add(1, 4'b0000, 4'b1000, 1, 0, 4'b1111, 4'b0000);
    // Lost again, with a third edge landing in the ack cycle.
    add(1, 4'b1000, 4'h0,    0, 0, 4'b1111, 4'b0000);
    add(1, 4'b0000, 4'h0,    0, 0, 4'b1111, 4'b0000);
    add(1, 4'b1000, 4'h0,    0, 0, 4'b1111, 4'b1000);
    add(1, 4'b0000, 4'h0,    0, 0, 4'b1111, 4'b1000);
    add(1, 4'b1000, 4'h0,    0, 0, 4'b1111, 4'b1000);
    add(1, 4'b0000, 4'h0,    0, 0, 4'b1111, 4'b1000);
    add(1, 4'b0000, 4'b1000, 1, 1, 4'b1111, 4'b1000);
    add(1, 4'b0000, 4'b1000, 1, 0, 4'b1011, 4'b0000);
    // Ack with nothing requesting.
    add(1, 4'b0000, 4'h0,    1, 0, 4'b0000, 4'b0000);
    // Reset mid-request discards pending.
    add(1, 4'b0001, 4'h0,    0, 0, 4'b0000, 4'b0000);
    add(1, 4'b0000, 4'h0,    0, 0, 4'b0000, 4'b0000);
    add(1, 4'b0000, 4'h0,    0, 0, 4'b0000, 4'b0001);
    add(0, 4'b0000, 4'b0001, 0, 0, 4'b0000, 4'b0000);
    add(1, 4'b0000, 4'b0001, 0, 0, 4'b0000, 4'b0000);

    foreach (vecs[k]) begin
      reset   = vecs[k].rst_n;
      bus.src = vecs[k].src;
      bus.ie  = vecs[k].ie;
      bus.ack = vecs[k].ack;
      tick();
      check($sformatf("vec%0d irq", k),   {3'b000, bus.irq}, {3'b000, vecs[k].irq});
      check($sformatf("vec%0d cause", k), bus.cause,         vecs[k].cause);
      check($sformatf("vec%0d pend", k),  bus.pending_o,     vecs[k].pend);
    end

    // Masking: pending kept while disabled, irq rises combinationally with ie.
    bus.src = 4'b0100; bus.ie = 4'h0; bus.ack = 1'b0;
    tick();
    bus.src = 4'b0000;
    tick();
    tick();
    check("mask irq off", {3'b000, bus.irq}, 4'b0000);
    check("mask pend",    bus.pending_o,     4'b0100);
    bus.ie = 4'b0100;
    #1;
    check("mask irq on",  {3'b000, bus.irq}, 4'b0001);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    check("mask cause",   bus.cause,         4'b1010);
    check("mask drained", bus.pending_o,     4'b0000);

    // Level-triggered source 0 on the second instance.
    lbus.ie = 4'b0001; lbus.src = 4'b0001;
    tick();
    tick();
    check("lvl irq early", {3'b000, lbus.irq}, 4'b0000);
    tick();
    check("lvl irq rise",  {3'b000, lbus.irq}, 4'b0001);
    lbus.ack = 1'b1;
    tick();
    lbus.ack = 1'b0;
    check("lvl cause",     lbus.cause,          4'b1000);
    check("lvl irq held",  {3'b000, lbus.irq}, 4'b0001);
    check("lvl pend held", lbus.pending_o,      4'b0001);
    lbus.src = 4'b0000;
    tick();
    tick();
    check("lvl irq lag",   {3'b000, lbus.irq}, 4'b0001);
    tick();
    check("lvl irq drop",  {3'b000, lbus.irq}, 4'b0000);
    lbus.ack = 1'b1;
    tick();
    lbus.ack = 1'b0;
    check("lvl no winner", lbus.cause,          4'b0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
